mux_arb: RTL



---
 rtl/mux_defs.sv | 32 +++
 rtl/rr_pick2.sv | 23 ++
 rtl/mux_arb.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mux_defs.sv
`default_nettype none
// ============================================================================
//  Module   : mux_defs (package)
//  Purpose  : Shared definitions for the router output mux and its wormhole
//             arbiter: flit type codes, arbiter state encoding, default width.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_defs;

  // Flit type codes carried in the top two bits of each flit
  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  // Arbiter states: idle, or locked onto input 0 / input 1
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  // Default width of the one-hot mux select
  localparam int PORTS_DEF = 5;

  // Map an input index onto its lock state
  function automatic state_t lock_state(input logic idx);
    return idx ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Combinational two-requester round-robin picker. The requester
//             named by rr_i wins a tie; a lone requester always wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic [1:0] pick_o
);

  // Resolve a tie in favour of the priority holder, otherwise pass through
  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) begin
      pick_o = rr_i ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb
//  Purpose  : Wormhole arbiter for the 2:1 router output mux. Locks the mux
//             onto one input from HEAD through TAIL, round-robin between
//             packets, drives the one-hot select and per-input grants.
//  Options  : MUX_ARB_TIMEOUT_EN - forced lock release after TIMEOUT stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_arb
  import mux_defs::*;
#(
  parameter int PORTS   = PORTS_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid_0,
  input  logic [1:0]       itype_0,
  input  logic             ivalid_1,
  input  logic [1:0]       itype_1,
  input  logic             ordy,
  output logic [PORTS-1:0] sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic             err,
  output logic             tmo
);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [PORTS-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic             first_q, first_d;

  logic             w_locked;
  logic             w_lk_idx;
  logic             w_oth;
  logic             w_lk_valid;
  logic [1:0]       w_lk_type;
  logic [1:0]       w_req;
  logic [1:0]       w_pick;
  logic             w_pick_rr;
  logic             w_xfer;

  assign w_locked   = (state_q == ST_LOCK0) || (state_q == ST_LOCK1);
  assign w_lk_idx   = (state_q == ST_LOCK1);
  assign w_oth      = ~w_lk_idx;
  assign w_lk_valid = w_lk_idx ? ivalid_1 : ivalid_0;
  assign w_lk_type  = w_lk_idx ? itype_1 : itype_0;
  assign w_req      = {ivalid_1 && (itype_1 == TYPE_HEAD),
                       ivalid_0 && (itype_0 == TYPE_HEAD)};

  // While locked, the picker sees the post-TAIL pointer (the other input)
  // so a waiting HEAD there is taken with no idle bubble.
  assign w_pick_rr = w_locked ? w_oth : rr_q;

  rr_pick2 u_pick (
    .req_i  (w_req),
    .rr_i   (w_pick_rr),
    .pick_o (w_pick)
  );

  // Grants depend only on registered state, valid and ordy (never on type)
  assign grant_0 = (state_q == ST_LOCK0) && ivalid_0 && ordy;
  assign grant_1 = (state_q == ST_LOCK1) && ivalid_1 && ordy;
  assign w_xfer  = grant_0 || grant_1;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          w_expire;
  assign w_expire = (cnt_q == CW'(TIMEOUT - 1));
  assign tmo      = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  // Next-state, pointer, error and select computation
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    err_d   = err_q;
    first_d = first_q;
`ifdef MUX_ARB_TIMEOUT_EN
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef MUX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (w_pick[0]) begin
          state_d = ST_LOCK0;
          first_d = 1'b1;
        end else if (w_pick[1]) begin
          state_d = ST_LOCK1;
          first_d = 1'b1;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        // A valid NONE flit on the locked input is a protocol error
        if (w_lk_valid && (w_lk_type == TYPE_NONE)) begin
          err_d = 1'b1;
        end
        if (w_xfer) begin
          first_d = 1'b0;
          // Only the opening transfer of a lock may carry a HEAD
          if ((w_lk_type == TYPE_HEAD) && !first_q) begin
            err_d = 1'b1;
          end
          if (w_lk_type == TYPE_TAIL) begin
            rr_d = w_oth;
            if (w_pick[w_oth]) begin
              state_d = lock_state(w_oth);
              first_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d = '0;
        end else if (w_expire) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
          rr_d    = w_oth;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sel_d    = '0;
    sel_d[0] = (state_d == ST_LOCK0);
    sel_d[1] = (state_d == ST_LOCK1);
  end

  // State and registered outputs; reset returns to idle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      first_q <= first_d;
`ifdef MUX_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign sel = sel_q;
  assign err = err_q;

endmodule
`default_nettype wire
